top: RTL and testbench

TOP -- requirements
Module: top

---
 rtl/top.sv | 230 +++++++++++++++++++++++
 tb/tb_top.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/top.sv
// Loopback UART: baud generator, transmitter and receiver, with the receiver fed from the TX line.
// Define UART_PARITY_EN for an 11-bit frame with parity; the default build uses a 10-bit frame without parity.
`timescale 1ns/1ps
module top #(
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    input  logic       p_sel,
    input  logic [1:0] baud_sel,
    input  logic [7:0] uart_data_tx_in,
    output logic       error,
    output logic [7:0] uart_data_rx_out,
    output logic       test
);

    localparam int unsigned DIV_2400   = CLK_FREQ / 2400;
    localparam int unsigned DIV_9600   = CLK_FREQ / 9600;
    localparam int unsigned DIV_57600  = CLK_FREQ / 57600;
    localparam int unsigned DIV_115200 = CLK_FREQ / 115200;
    localparam int          CNT_W      = $clog2(DIV_2400 + 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    typedef struct packed {
        logic [7:0] data;
        logic [1:0] baud;
    } tx_cfg_t;

    tx_cfg_t          cfg;
    state_t           tx_state;
    state_t           rx_state;
    logic [CNT_W-1:0] bit_div;
    logic [CNT_W-1:0] bit_last;
    logic [CNT_W-1:0] half_last;
    logic [CNT_W-1:0] tx_cnt;
    logic [CNT_W-1:0] rx_cnt;
    logic             tx_tick;
    logic [2:0]       tx_bit;
    logic [2:0]       rx_bit;
    logic [7:0]       rx_shift;
    logic             rx_prev;
`ifdef UART_PARITY_EN
    logic             tx_odd;
    logic             rx_par_err;
`else
    logic             unused_p_sel;
    assign unused_p_sel = p_sel;
`endif

    // Baud generator: the divisor follows the baud select latched at frame start,
    // so both TX and RX keep a stable bit period for the whole frame.
    always_comb begin
        // NOTE: default assignment first so every path drives bit_div and no latch is inferred.
        bit_div = CNT_W'(DIV_115200);
        case (cfg.baud)
            2'b00:   bit_div = CNT_W'(DIV_2400);
            2'b01:   bit_div = CNT_W'(DIV_9600);
            2'b10:   bit_div = CNT_W'(DIV_57600);
            default: bit_div = CNT_W'(DIV_115200);
        endcase
    end

    assign bit_last  = bit_div - CNT_W'(1);
    assign half_last = (bit_div >> 1) - CNT_W'(1);
    assign tx_tick   = (tx_cnt == bit_last);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses <= so every register sees pre-edge values of the others.
        if (!rst || tx_state == IDLE || tx_tick) begin
            tx_cnt <= '0;
        end else begin
            tx_cnt <= tx_cnt + CNT_W'(1);
        end
    end

    // Transmitter: test is registered and changes only on state transitions or bit ticks.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tx_state <= IDLE;
            tx_bit   <= '0;
            cfg      <= '0;
            test     <= 1'b1;
`ifdef UART_PARITY_EN
            tx_odd   <= 1'b0;
`endif
        end else begin
            case (tx_state)
                IDLE: begin
                    test <= 1'b1;
                    if (ready) begin
                        cfg.data <= uart_data_tx_in;
                        cfg.baud <= baud_sel;
`ifdef UART_PARITY_EN
                        tx_odd   <= p_sel;
`endif
                        tx_state <= START;
                        test     <= 1'b0;
                    end
                end
                START: begin
                    if (tx_tick) begin
                        tx_state <= DATA;
                        tx_bit   <= '0;
                        test     <= cfg.data[0];
                    end
                end
                DATA: begin
                    if (tx_tick) begin
                        if (tx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            tx_state <= PARITY;
                            test     <= (^cfg.data) ^ tx_odd;
`else
                            tx_state <= STOP;
                            test     <= 1'b1;
`endif
                        end else begin
                            tx_bit <= tx_bit + 3'd1;
                            test   <= cfg.data[tx_bit + 3'd1];
                        end
                    end
                end
                PARITY: begin
                    if (tx_tick) begin
                        tx_state <= STOP;
                        test     <= 1'b1;
                    end
                end
                STOP: begin
                    if (tx_tick) begin
                        tx_state <= IDLE;
                    end
                end
                default: begin
                    tx_state <= IDLE;
                    test     <= 1'b1;
                end
            endcase
        end
    end

    // Receiver: rx_cnt is preloaded to 1 while idle so the detection clock counts
    // toward the half-bit start check; later bits are sampled one full period apart.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_state         <= IDLE;
            rx_cnt           <= '0;
            rx_bit           <= '0;
            rx_shift         <= '0;
            rx_prev          <= 1'b1;
            error            <= 1'b0;
            uart_data_rx_out <= 8'h00;
`ifdef UART_PARITY_EN
            rx_par_err       <= 1'b0;
`endif
        end else begin
            rx_prev <= test;
            case (rx_state)
                IDLE: begin
                    rx_cnt <= CNT_W'(1);
                    if (rx_prev && !test) begin
                        rx_state <= START;
                    end
                end
                START: begin
                    if (rx_cnt == half_last) begin
                        rx_cnt   <= '0;
                        rx_bit   <= '0;
                        rx_state <= test ? IDLE : DATA;
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (rx_cnt == bit_last) begin
                        rx_cnt   <= '0;
                        rx_shift <= {test, rx_shift[7:1]};
                        rx_bit   <= rx_bit + 3'd1;
                        if (rx_bit == 3'd7) begin
`ifdef UART_PARITY_EN
                            rx_state <= PARITY;
`else
                            rx_state <= STOP;
`endif
                        end
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                PARITY: begin
                    if (rx_cnt == bit_last) begin
                        rx_cnt   <= '0;
                        rx_state <= STOP;
`ifdef UART_PARITY_EN
                        rx_par_err <= test ^ (^rx_shift) ^ tx_odd;
`endif
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (rx_cnt == bit_last) begin
                        rx_cnt           <= '0;
                        rx_state         <= IDLE;
                        uart_data_rx_out <= rx_shift;
`ifdef UART_PARITY_EN
                        error            <= ~test | rx_par_err;
`else
                        error            <= ~test;
`endif
                    end else begin
                        rx_cnt <= rx_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    rx_state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top.sv
// Testbench for top: one instance at the default clock for exact bit-time checks and a
// second at a reduced clock so slow-baud and randomized back-to-back frames stay short.
`timescale 1ns/1ps
module tb_top;

    localparam int BIG_FREQ   = 50000000;
    localparam int SMALL_FREQ = 2000000;
`ifdef UART_PARITY_EN
    localparam int NB = 11;
`else
    localparam int NB = 10;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic       b_rst, b_ready, b_psel, b_err, b_test;
    logic [1:0] b_baud;
    logic [7:0] b_din, b_dout;
    logic       s_rst, s_ready, s_psel, s_err, s_test;
    logic [1:0] s_baud;
    logic [7:0] s_din, s_dout;

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] last_rx [2];

    top dut (
        .clk(clk), .rst(b_rst), .ready(b_ready), .p_sel(b_psel), .baud_sel(b_baud),
        .uart_data_tx_in(b_din), .error(b_err), .uart_data_rx_out(b_dout), .test(b_test)
    );

    top #(.CLK_FREQ(SMALL_FREQ)) dut_s (
        .clk(clk), .rst(s_rst), .ready(s_ready), .p_sel(s_psel), .baud_sel(s_baud),
        .uart_data_tx_in(s_din), .error(s_err), .uart_data_rx_out(s_dout), .test(s_test)
    );

    function automatic int baud_rate(input logic [1:0] sel);
        case (sel)
            2'b00:   return 2400;
            2'b01:   return 9600;
            2'b10:   return 57600;
            default: return 115200;
        endcase
    endfunction

    function automatic int bit_clocks(input bit s, input logic [1:0] sel);
        return (s ? SMALL_FREQ : BIG_FREQ) / baud_rate(sel);
    endfunction

    // Serial frame model: start, data LSB first, optional parity, stop.
    function automatic logic expected_bit(input logic [7:0] d, input logic odd, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return d[k-1];
`ifdef UART_PARITY_EN
        if (k == 9) return logic'($countones(d) % 2) ^ odd;
`endif
        return 1'b1;
    endfunction

    function automatic logic line_of(input bit s);
        return s ? s_test : b_test;
    endfunction

    function automatic logic [7:0] rx_of(input bit s);
        return s ? s_dout : b_dout;
    endfunction

    function automatic logic err_of(input bit s);
        return s ? s_err : b_err;
    endfunction

    task automatic drive(input bit s, input logic r, input logic [7:0] d, input logic o,
                         input logic [1:0] b);
        if (s) begin
            s_ready = r; s_din = d; s_psel = o; s_baud = b;
        end else begin
            b_ready = r; b_din = d; b_psel = o; b_baud = b;
        end
    endtask

    // Watches one frame from its first low clock: per-bit level/duration, receive latency,
    // received byte and error. Inputs for the following frame are applied at stop-bit start.
    task automatic run_frame(input bit s, input logic [7:0] d, input logic odd,
                             input logic [1:0] sel, input bit scramble, input logic next_ready,
                             input logic [7:0] next_d, input logic next_odd,
                             input logic [1:0] next_sel, output int t0);
        int div, lat, guard, hits, bound;
        logic [7:0] prev;
        string tag;
        div   = bit_clocks(s, sel);
        prev  = last_rx[s];
        tag   = s ? "s" : "b";
        bound = 4 * div + 16;
        guard = 0;
        t0    = -1;
        while (line_of(s) !== 1'b0 && guard < bound) begin
            @(negedge clk);
            guard++;
        end
        vectors++;
        if (line_of(s) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_start_timeout: line=%b, required 0 within %0d clocks", tag, line_of(s), bound);
            return;
        end
        t0  = cyc;
        lat = -1;
        for (int k = 0; k < NB; k++) begin
            hits = 0;
            for (int c = 0; c < div; c++) begin
                if (k != 0 || c != 0) @(negedge clk);
                if (c == 0) begin
                    if (k == NB - 1) drive(s, next_ready, next_d, next_odd, next_sel);
                    else if (scramble) drive(s, 1'($urandom), 8'($urandom), 1'($urandom), 2'($urandom));
                end
                if (line_of(s) === expected_bit(d, odd, k)) hits++;
                if (lat < 0 && rx_of(s) !== prev) lat = k * div + c;
            end
            vectors++;
            if (hits != div) begin
                miscompares++;
                $display("FAIL %s_bit%0d (data %h): %0d clocks at level %b, required %0d", tag, k, d, hits, expected_bit(d, odd, k), div);
            end
        end
        if (d !== prev) begin
            vectors++;
            if (lat != div / 2 + (NB - 1) * div) begin
                miscompares++;
                $display("FAIL %s_rx_latency: %0d clocks, required %0d", tag, lat, div / 2 + (NB - 1) * div);
            end
        end
        vectors++;
        if (rx_of(s) !== d) begin
            miscompares++;
            $display("FAIL %s_rx_data: got %h, required %h", tag, rx_of(s), d);
        end
        vectors++;
        if (err_of(s) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_rx_error: got %b, required 0", tag, err_of(s));
        end
        last_rx[s] = d;
    endtask

    task automatic test_reset();
        drive(0, 1'b0, 8'h00, 1'b0, 2'b00);
        drive(1, 1'b0, 8'h00, 1'b0, 2'b00);
        b_rst = 1'b0;
        s_rst = 1'b0;
        repeat (2) @(negedge clk);
        for (int s = 0; s < 2; s++) begin
            vectors++;
            if (line_of(1'(s)) !== 1'b1) begin
                miscompares++;
                $display("FAIL reset_test[%0d]: got %b, required 1", s, line_of(1'(s)));
            end
            vectors++;
            if (err_of(1'(s)) !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_error[%0d]: got %b, required 0", s, err_of(1'(s)));
            end
            vectors++;
            if (rx_of(1'(s)) !== 8'h00) begin
                miscompares++;
                $display("FAIL reset_rx[%0d]: got %h, required 00", s, rx_of(1'(s)));
            end
            last_rx[s] = 8'h00;
        end
        b_rst = 1'b1;
        s_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_even_parity();
        int t0;
        drive(0, 1'b1, 8'hAA, 1'b0, 2'b11);
        run_frame(0, 8'hAA, 1'b0, 2'b11, 0, 1'b0, 8'hAA, 1'b0, 2'b11, t0);
    endtask

    task automatic test_odd_parity();
        int t0;
        drive(0, 1'b1, 8'hAA, 1'b1, 2'b11);
        run_frame(0, 8'hAA, 1'b1, 2'b11, 0, 1'b0, 8'hAA, 1'b1, 2'b11, t0);
    endtask

    task automatic test_idle_line();
        int hits = 0;
        drive(0, 1'b0, 8'h0F, 1'b0, 2'b11);
        for (int i = 0; i < 10000; i++) begin
            @(negedge clk);
            if (b_test === 1'b1) hits++;
        end
        vectors++;
        if (hits != 10000) begin
            miscompares++;
            $display("FAIL idle_line: %0d of 10000 clocks high", hits);
        end
        vectors++;
        if (b_dout !== last_rx[0]) begin
            miscompares++;
            $display("FAIL idle_rx: got %h, required %h", b_dout, last_rx[0]);
        end
    endtask

    task automatic test_reset_mid_frame();
        int guard = 0;
        int hits  = 0;
        int div   = bit_clocks(0, 2'b11);
        int t0;
        drive(0, 1'b1, 8'hA1, 1'b0, 2'b11);
        while (b_test !== 1'b0 && guard < 4 * div) begin
            @(negedge clk);
            guard++;
        end
        repeat (3 * div) @(negedge clk);
        b_rst = 1'b0;
        b_ready = 1'b0;
        @(negedge clk);
        vectors++;
        if (b_test !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_test: got %b, required 1", b_test);
        end
        last_rx[0] = 8'h00;
        vectors++;
        if (b_dout !== 8'h00 || b_err !== 1'b0) begin
            miscompares++;
            $display("FAIL abort_outputs: rx=%h err=%b, required rx=00 err=0", b_dout, b_err);
        end
        @(negedge clk);
        b_rst = 1'b1;
        for (int i = 0; i < 12 * div; i++) begin
            @(negedge clk);
            if (b_test === 1'b1) hits++;
        end
        vectors++;
        if (hits != 12 * div) begin
            miscompares++;
            $display("FAIL abort_line_idle: %0d of %0d clocks high", hits, 12 * div);
        end
        vectors++;
        if (b_dout !== 8'h00) begin
            miscompares++;
            $display("FAIL abort_no_update: got %h, required 00", b_dout);
        end
        drive(0, 1'b1, 8'h5A, 1'b0, 2'b11);
        run_frame(0, 8'h5A, 1'b0, 2'b11, 0, 1'b0, 8'h5A, 1'b0, 2'b11, t0);
    endtask

    task automatic test_slow_baud();
        int t0;
        drive(1, 1'b1, 8'h55, 1'b0, 2'b00);
        run_frame(1, 8'h55, 1'b0, 2'b00, 0, 1'b0, 8'h55, 1'b0, 2'b00, t0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] d [13];
        logic       o [13];
        logic [1:0] b [13];
        int t0, prev_t0;
        for (int i = 0; i < 13; i++) begin
            d[i] = 8'($urandom);
            o[i] = 1'($urandom);
            b[i] = 2'($urandom_range(1, 3));
        end
        prev_t0 = -1;
        drive(1, 1'b1, d[0], o[0], b[0]);
        for (int i = 0; i < 12; i++) begin
            run_frame(1, d[i], o[i], b[i], 1, 1'(i < 11), d[i+1], o[i+1], b[i+1], t0);
            if (i > 0) begin
                vectors++;
                if (t0 - prev_t0 != NB * bit_clocks(1, b[i-1]) + 1) begin
                    miscompares++;
                    $display("FAIL b2b_gap%0d: %0d clocks between starts, required %0d", i, t0 - prev_t0, NB * bit_clocks(1, b[i-1]) + 1);
                end
            end
            prev_t0 = t0;
        end
    endtask

    initial begin
        test_reset();
        test_even_parity();
        test_odd_parity();
        test_idle_line();
        test_reset_mid_frame();
        test_slow_baud();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
